alu_aux_arbiter: RTL and testbench
==================================

// Module: alu_aux_arbiter
// PURPOSE
//  Shares one alu_aux instance between two requesters: port 0 = execute stage, port 1 = branch/CSR helper.
//  Round-robin grant, at most one operation per cycle. Valid/ready handshake on each request port.
//  Each requester owns a one-entry response register; result appears exactly 1 cycle after its grant.
//  The ALU is combinational and sits outside this block; its op_type/op0/op1/is_word_op are driven from here.
// PARAMETERS
//  XLEN      64  datapath width (32 when RV64 is not defined)
//  OPT_W     16  op_type one-hot bus width, same encoding as the ALU's op_type
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst             in   1          synchronous reset, active-high
//  req_valid[1:0]  in   2          request present, per port
//  req_ready[1:0]  out  2          request accepted this cycle (grant), per port
//  req_op_type0/1  in   OPT_W      one-hot operation, per port
//  req_op0_0/1     in   XLEN       first operand, per port
//  req_op1_0/1     in   XLEN       second operand / shamt / imm, per port
//  req_word0/1     in   1          RV64 word-op flag, per port (ignored when XLEN=32)
//  resp_valid[1:0] out  2          response register full, per port
//  resp_ready[1:0] in   2          requester consumes response, per port
//  resp_data0/1    out  XLEN       registered ALU result, per port
//  alu_op_type     out  OPT_W      to ALU
//  alu_op0         out  XLEN       to ALU
//  alu_op1         out  XLEN       to ALU
//  alu_is_word_op  out  1          to ALU
//  alu_res         in   XLEN       from ALU, combinational
// BEHAVIOUR
//  Reset: resp_valid=0, resp_data0/1=0, rr_ptr=0 (port 0 has priority), req_ready=0.
//  Slot free condition, per port i: free_i = !resp_valid[i] | resp_ready[i].
//   - A full slot being drained this cycle counts as free (back-to-back issue).
//  Eligibility: elig_i = req_valid[i] & free_i.
//  Grant:
//   - Only one eligible port: that port is granted.
//   - Both eligible: port rr_ptr is granted.
//   - Neither eligible: no grant.
//   - req_ready = one-hot grant or 0. Combinational from req_valid, resp_valid and resp_ready.
//  ALU drive:
//   - Granted port's op_type/op0/op1/word are muxed to alu_*.
//   - No grant: all alu_* = 0. The ALU ORs its sub-results, so op_type=0 forces alu_res=0.
//  rr_ptr update: after any grant, rr_ptr <= ~granted_port. Unchanged when no grant.
//  Response register i, per cycle, in priority order:
//   - Grant to i: resp_data_i <= alu_res, resp_valid[i] <= 1. This overrides a simultaneous drain.
//   - Else resp_valid[i] & resp_ready[i]: resp_valid[i] <= 0, resp_data_i keeps its value.
//   - Else hold.
//  Latency: grant in cycle N -> resp_valid high in cycle N+1 -> held until resp_ready.
//  Throughput: 1 op/cycle total. A single port sustains 1 op/cycle when resp_ready is held high.
//  Operands are sampled only in the grant cycle. The requester must hold req_* stable while req_valid & !req_ready.
//  resp_ready while resp_valid=0: no effect.
//  Illegal op_type (not one-hot): passed through unchecked. The result is whatever the ALU returns.
//  Reset mid-operation: pending responses are discarded, rr_ptr returns to 0. No grant in the reset cycle.
// TESTING
//  1. Single add: port 0, op=ADD, op0=5, op1=7, resp_ready=1
//     -> req_ready[0]=1 in cycle N; resp_valid[0]=1 and resp_data0=12 in N+1.
//  2. Contention: both ports valid every cycle, port 0 ADD 1+1, port 1 SUB 10-3, both resp_ready=1
//     -> grants alternate 0,1,0,1; resp_data0=2, resp_data1=7.
//  3. Backpressure: port 1 resp_ready=0, issue SLL 1<<4
//     -> resp_data1=16 held; next port-1 request stays req_ready=0 for 5 cycles.
//     -> Raise resp_ready: same-cycle grant, new result replaces old with no gap.
//  4. Idle ALU: no req_valid -> alu_op_type=0, alu_op0=0, alu_op1=0, resp_valid unchanged.
//  5. RV64 word op: port 0 ADDW op0=0x7FFF_FFFF, op1=1, word=1 -> resp_data0=0xFFFF_FFFF_8000_0000.
//  6. Reset mid-op: rst in the cycle after a grant -> resp_valid=00, rr_ptr=0.
//     -> First post-reset contention grants port 0.

Source files
------------

// File: rtl/alu_aux_arbiter.sv
// Round-robin arbiter sharing one combinational alu_aux between the execute stage
// (port 0) and the branch/CSR helper (port 1), with a one-entry response register per port.
module alu_aux_arbiter #(
  parameter int XLEN  = 64,
  parameter int OPT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPT_W-1:0] req_op_type0,
  input  logic [OPT_W-1:0] req_op_type1,
  input  logic [XLEN-1:0]  req_op0_0,
  input  logic [XLEN-1:0]  req_op0_1,
  input  logic [XLEN-1:0]  req_op1_0,
  input  logic [XLEN-1:0]  req_op1_1,
  input  logic             req_word0,
  input  logic             req_word1,

  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [XLEN-1:0]  resp_data0,
  output logic [XLEN-1:0]  resp_data1,

  output logic [OPT_W-1:0] alu_op_type,
  output logic [XLEN-1:0]  alu_op0,
  output logic [XLEN-1:0]  alu_op1,
  output logic             alu_is_word_op,
  input  logic [XLEN-1:0]  alu_res
);

  logic [1:0] slot_free;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       rr_ptr;

  // A slot being drained this cycle is free, allowing back-to-back issue per port.
  always_comb begin
    slot_free = ~resp_valid | resp_ready;
    elig      = req_valid & slot_free;
    grant     = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) begin
        grant = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;

  // Idle ALU inputs are zeroed so the OR-combined ALU result is zero too.
  always_comb begin
    alu_op_type    = '0;
    alu_op0        = '0;
    alu_op1        = '0;
    alu_is_word_op = 1'b0;
    if (grant[0]) begin
      alu_op_type    = req_op_type0;
      alu_op0        = req_op0_0;
      alu_op1        = req_op1_0;
      alu_is_word_op = (XLEN == 64) ? req_word0 : 1'b0;
    end else if (grant[1]) begin
      alu_op_type    = req_op_type1;
      alu_op0        = req_op0_1;
      alu_op1        = req_op1_1;
      alu_is_word_op = (XLEN == 64) ? req_word1 : 1'b0;
    end
  end

  // A new grant into a slot wins over a simultaneous drain of the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      resp_valid <= 2'b00;
      resp_data0 <= '0;
      resp_data1 <= '0;
    end else begin
      if (|grant) begin
        rr_ptr <= grant[0];
      end

      if (grant[0]) begin
        resp_valid[0] <= 1'b1;
        resp_data0    <= alu_res;
      end else if (resp_valid[0] && resp_ready[0]) begin
        resp_valid[0] <= 1'b0;
      end

      if (grant[1]) begin
        resp_valid[1] <= 1'b1;
        resp_data1    <= alu_res;
      end else if (resp_valid[1] && resp_ready[1]) begin
        resp_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_aux_arbiter.sv
// Testbench for alu_aux_arbiter: directed scenarios followed by randomized traffic,
// checked against a cycle-level reference model of the arbitration and response slots.
module tb_alu_aux_arbiter;

  localparam int XLEN  = 64;
  localparam int OPT_W = 16;

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0002;
  localparam logic [15:0] OP_SLL = 16'h0004;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [15:0]      op_t [2];
  logic [63:0]      a_op [2];
  logic [63:0]      b_op [2];
  logic             wd   [2];
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [63:0]      resp_data0;
  logic [63:0]      resp_data1;
  logic [15:0]      alu_op_type;
  logic [63:0]      alu_op0;
  logic [63:0]      alu_op1;
  logic             alu_is_word_op;
  logic [63:0]      alu_res;

  always #5 clk = ~clk;

  alu_aux_arbiter #(.XLEN(XLEN), .OPT_W(OPT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op_type0   (op_t[0]),
    .req_op_type1   (op_t[1]),
    .req_op0_0      (a_op[0]),
    .req_op0_1      (a_op[1]),
    .req_op1_0      (b_op[0]),
    .req_op1_1      (b_op[1]),
    .req_word0      (wd[0]),
    .req_word1      (wd[1]),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data0     (resp_data0),
    .resp_data1     (resp_data1),
    .alu_op_type    (alu_op_type),
    .alu_op0        (alu_op0),
    .alu_op1        (alu_op1),
    .alu_is_word_op (alu_is_word_op),
    .alu_res        (alu_res)
  );

  // External ALU stand-in: one-hot ops, sub-results ORed together.
  function automatic logic [63:0] alu_model(input logic [15:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic w);
    logic [63:0] r;
    logic [31:0] t;
    r = '0;
    if (op[0]) begin
      t = a[31:0] + b[31:0];
      r |= w ? {{32{t[31]}}, t} : a + b;
    end
    if (op[1]) begin
      t = a[31:0] - b[31:0];
      r |= w ? {{32{t[31]}}, t} : a - b;
    end
    if (op[2]) begin
      t = a[31:0] << b[4:0];
      r |= w ? {{32{t[31]}}, t} : a << b[5:0];
    end
    if (op[3]) r |= a ^ b;
    if (op[4]) r |= a & b;
    if (op[5]) r |= a | b;
    return r;
  endfunction

  always_comb alu_res = alu_model(alu_op_type, alu_op0, alu_op1, alu_is_word_op);

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: which port wins a tie, and the expected response slots.
  int          m_pref;
  logic [1:0]  m_rv;
  logic [63:0] m_rd [2];
  int          last_g;
  logic [1:0]  obs_rr;
  logic [15:0] obs_alu_op;
  logic [1:0]  t2_rr [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle();
    logic [1:0]  el;
    int          g;
    logic [63:0] r;
    #3;
    for (int i = 0; i < 2; i++) el[i] = req_valid[i] && (!m_rv[i] || resp_ready[i]);
    g = -1;
    if (!rst) begin
      if (el == 2'b11)  g = m_pref;
      else if (el[0])   g = 0;
      else if (el[1])   g = 1;
    end
    obs_rr     = req_ready;
    obs_alu_op = alu_op_type;
    r          = '0;
    if (g < 0) begin
      chk("req_ready_idle", req_ready, 64'd0);
      chk("alu_idle", {alu_op_type, alu_is_word_op, alu_op0, alu_op1} == '0, 64'd1);
    end else begin
      chk("req_ready_grant", req_ready, 64'd1 << g);
      chk("alu_op_type", {alu_op_type, alu_is_word_op}, {op_t[g], wd[g]});
      chk("alu_op0", alu_op0, a_op[g]);
      chk("alu_op1", alu_op1, b_op[g]);
      r = alu_model(op_t[g], a_op[g], b_op[g], wd[g]);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pref = 0;
      m_rv   = 2'b00;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          m_rv[i] = 1'b1;
          m_rd[i] = r;
        end else if (m_rv[i] && resp_ready[i]) begin
          m_rv[i] = 1'b0;
        end
      end
      if (g >= 0) m_pref = 1 - g;
    end
    last_g = g;
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_data0", resp_data0, m_rd[0]);
    chk("resp_data1", resp_data1, m_rd[1]);
  endtask

  task automatic set_req(input int p, input logic [15:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic w);
    op_t[p] = op;
    a_op[p] = a;
    b_op[p] = b;
    wd[p]   = w;
  endtask

  initial begin
    logic [1:0] pend;
    int         k;
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    set_req(0, 16'h0, 64'h0, 64'h0, 1'b0);
    set_req(1, 16'h0, 64'h0, 64'h0, 1'b0);
    m_pref = 0;
    m_rv   = 2'b00;
    m_rd[0] = '0;
    m_rd[1] = '0;
    last_g = -1;

    // Reset state
    cycle();
    cycle();
    chk("reset_resp_valid", resp_valid, 64'd0);

    // 1. Single add on port 0
    rst        = 1'b0;
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    set_req(0, OP_ADD, 64'd5, 64'd7, 1'b0);
    cycle();
    chk("t1_grant", obs_rr, 64'd1);
    chk("t1_valid", resp_valid[0], 64'd1);
    chk("t1_data", resp_data0, 64'd12);

    // 2. Contention from a fresh reset: grants alternate starting at port 0
    req_valid = 2'b00;
    rst       = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = 2'b11;
    set_req(0, OP_ADD, 64'd1, 64'd1, 1'b0);
    set_req(1, OP_SUB, 64'd10, 64'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      t2_rr[i] = obs_rr;
    end
    chk("t2_grant0", t2_rr[0], 64'd1);
    chk("t2_grant1", t2_rr[1], 64'd2);
    chk("t2_grant2", t2_rr[2], 64'd1);
    chk("t2_grant3", t2_rr[3], 64'd2);
    chk("t2_data0", resp_data0, 64'd2);
    chk("t2_data1", resp_data1, 64'd7);
    req_valid = 2'b00;
    cycle();

    // 3. Backpressure on port 1
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    set_req(1, OP_SLL, 64'd1, 64'd4, 1'b0);
    cycle();
    chk("t3_grant", obs_rr, 64'd2);
    set_req(1, OP_ADD, 64'd3, 64'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_stall", obs_rr, 64'd0);
      chk("t3_held", resp_data1, 64'd16);
    end
    resp_ready = 2'b11;
    cycle();
    chk("t3_regrant", obs_rr, 64'd2);
    chk("t3_valid", resp_valid[1], 64'd1);
    chk("t3_data", resp_data1, 64'd7);

    // 4. Idle ALU with responses left unconsumed
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t4_alu_op", obs_alu_op, 64'd0);
      chk("t4_resp_valid", resp_valid, 64'd2);
    end

    // 5. RV64 word add
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    set_req(0, OP_ADD, 64'h7FFF_FFFF, 64'd1, 1'b1);
    cycle();
    chk("t5_data", resp_data0, 64'hFFFF_FFFF_8000_0000);

    // 6. Reset right after a port-0 grant, then contention must favour port 0
    rst       = 1'b1;
    req_valid = 2'b11;
    set_req(1, OP_SUB, 64'd9, 64'd2, 1'b0);
    cycle();
    chk("t6_no_grant", obs_rr, 64'd0);
    chk("t6_resp_valid", resp_valid, 64'd0);
    rst = 1'b0;
    cycle();
    chk("t6_first_grant", obs_rr, 64'd1);

    // Randomized traffic; a stalled request is held stable until granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) pend[i] = req_valid[i] && (last_g != i) && !rst;
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          k = $urandom_range(0, 6);
          op_t[i] = (k == 6) ? 16'($urandom) : (16'h1 << k);
          a_op[i] = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 100));
          b_op[i] = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
          wd[i]   = 1'($urandom);
        end
      end
      resp_ready = 2'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
